// File: rtl/ram_access_controller_pkg.sv
// Shared types for the RAM access controller: controller states and buffer sizing.
package ram_access_controller_pkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        CLEAR      = 2'd1,
        OPERATE    = 2'd2
    } ctrl_state_e;

    localparam int RESPONSE_BUFFER_DEPTH = 2;

endpackage

// File: rtl/ram_access_response_buffer.sv
// Two-entry response FIFO. Entry 0 is always the head; a pop shifts entry 1 down.
module ram_access_response_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;

    // A push lands in the first slot that is free after this cycle's pop.
    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        if (pop) begin
            entry0_d = entry1_q;
        end
        if (push) begin
            if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
                entry0_d = push_data;
            end else begin
                entry1_d = push_data;
            end
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head  = entry0_q;
    assign count = count_q;

endmodule

// File: rtl/ram_access_controller.sv
// Valid/ready front end for one port of a RAM with a one-cycle registered read,
// including an optional clear sweep and a two-entry response buffer.
module ram_access_controller
    import ram_access_controller_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter int               DEPTH          = 16,
    parameter int               ADDRESS_WIDTH  = $clog2(DEPTH),
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     busy,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic                     request_write,
    input  logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic [WIDTH-1:0]         request_write_data,
    output logic                     response_valid,
    input  logic                     response_ready,
    output logic [WIDTH-1:0]         response_read_data,
    output logic                     ram_access_enable,
    output logic                     ram_write,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0]         ram_write_data,
    input  logic [WIDTH-1:0]         ram_read_data
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

    ctrl_state_e              state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] counter_q, counter_d;
    logic                     in_flight_q, in_flight_d;

    logic [WIDTH-1:0] buf_head;
    logic [1:0]       buf_count;
    logic             buf_push;
    logic             buf_pop;
    logic [1:0]       occupancy;
    logic [1:0]       occupancy_after_consume;
    logic             consumed;
    logic             read_ok;
    logic             accept;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            RESET_HOLD: begin
                state_d   = CLEAR_ON_RESET ? CLEAR : OPERATE;
                counter_d = '0;
            end
            CLEAR: begin
                if (counter_q == LAST_ADDRESS) begin
                    state_d   = OPERATE;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + ADDRESS_WIDTH'(1);
                end
            end
            OPERATE: begin
                if (clear) begin
                    state_d   = CLEAR;
                    counter_d = '0;
                end
            end
            default: begin
                state_d   = RESET_HOLD;
                counter_d = '0;
            end
        endcase
    end

    // Response side: an empty buffer lets the RAM data pass straight through,
    // otherwise the head is shown and fresh RAM data queues behind it.
    always_comb begin
        response_valid          = in_flight_q | (buf_count != 2'd0);
        response_read_data      = (buf_count == 2'd0) ? ram_read_data : buf_head;
        consumed                = response_valid & response_ready;
        buf_pop                 = (buf_count != 2'd0) & response_ready;
        buf_push                = in_flight_q & ~((buf_count == 2'd0) & response_ready);
        occupancy               = {1'b0, in_flight_q} + buf_count;
        occupancy_after_consume = occupancy - {1'b0, consumed};
        read_ok                 = occupancy_after_consume < 2'd2;
    end

    always_comb begin
        busy              = (state_q != OPERATE);
        request_ready     = 1'b0;
        ram_access_enable = 1'b0;
        ram_write         = 1'b0;
        ram_address       = '0;
        ram_write_data    = '0;
        accept            = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_access_enable = 1'b1;
                ram_write         = 1'b1;
                ram_address       = counter_q;
                ram_write_data    = CLEAR_VALUE;
            end
            OPERATE: begin
                request_ready     = request_write | read_ok;
                accept            = request_valid & request_ready;
                ram_access_enable = accept;
                ram_write         = request_write;
                ram_address       = request_address;
                ram_write_data    = request_write_data;
            end
            default: begin
                ram_access_enable = 1'b0;
            end
        endcase
        in_flight_d = accept & ~request_write;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_HOLD;
            counter_q   <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            in_flight_q <= in_flight_d;
        end
    end

    ram_access_response_buffer #(
        .WIDTH(WIDTH)
    ) u_response_buffer (
        .clock     (clock),
        .reset     (reset),
        .push      (buf_push),
        .push_data (ram_read_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count)
    );

endmodule
